// File: rtl/tx_nco_ctrl_pkg.sv
// Shared types and defaults for the TX NCO frequency controller.
package tx_nco_ctrl_pkg;

    localparam int unsigned APR_DEF       = 32;
    localparam int unsigned NCO_LAT_DEF   = 10;
    localparam int unsigned RAMP_HOLD_DEF = 64;
    localparam int unsigned KW_DEF        = 4;

    // Signed difference of two unsigned APR-bit words needs one extra bit.
    function automatic int unsigned delta_w(input int unsigned apr);
        return apr + 1;
    endfunction

    localparam int unsigned DELTA_W = delta_w(APR_DEF);

    typedef enum logic [2:0] {
        OFF,
        WARMUP,
        RUN,
        RAMP,
        SETTLE
    } state_e;

endpackage

// File: rtl/tx_nco_ramp_gen.sv
// Phase-continuous linear ramp of the NCO phase increment in 2^k held steps.
module tx_nco_ramp_gen
    import tx_nco_ctrl_pkg::*;
#(
    parameter int unsigned APR       = APR_DEF,
    parameter int unsigned RAMP_HOLD = RAMP_HOLD_DEF,
    parameter int unsigned KW        = KW_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [KW-1:0]  k,
    input  logic [APR-1:0] current,
    input  logic [APR-1:0] target,
    input  logic           enable,
    input  logic           abort,
    output logic [APR-1:0] phi_out_c,
    output logic           done_c
);

    localparam int unsigned DW     = delta_w(APR);
    localparam int unsigned HOLD_W = (RAMP_HOLD > 1) ? $clog2(RAMP_HOLD) : 1;
    localparam int unsigned STEP_W = 2 ** KW;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RAMP_HOLD - 1);
    // The accept cycle counts as hold cycle 0; with a one-cycle hold it is also the first update.
    localparam logic [HOLD_W-1:0] HOLD_INIT = (RAMP_HOLD > 1) ? HOLD_W'(1) : '0;
    localparam logic [STEP_W-1:0] STEP_INIT = (RAMP_HOLD > 1) ? '0 : STEP_W'(1);

    logic [HOLD_W-1:0]    hold_cnt;
    logic [STEP_W-1:0]    step_cnt;
    logic [STEP_W-1:0]    last_idx;
    logic [KW-1:0]        k_q;
    logic signed [DW-1:0] delta_c;
    logic signed [DW-1:0] step_c;
    logic signed [DW-1:0] step_q;
    logic signed [DW-1:0] step_use_c;
    logic                 wrap_c;
    logic                 last_c;

    // Step size, update strobe and next phase increment.
    always_comb begin
        delta_c    = $signed({1'b0, target}) - $signed({1'b0, current});
        step_c     = delta_c >>> k;
        step_use_c = start ? step_c : step_q;
        last_idx   = (STEP_W'(1) << k_q) - STEP_W'(1);
        wrap_c     = (enable && (hold_cnt == HOLD_LAST)) || (start && (RAMP_HOLD == 1));
        last_c     = !start && (step_cnt == last_idx);
        done_c     = wrap_c && last_c;
        phi_out_c  = current;
        if (done_c) begin
            phi_out_c = target;
        end else if (wrap_c) begin
            phi_out_c = APR'($signed({1'b0, current}) + step_use_c);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            hold_cnt <= '0;
            step_cnt <= '0;
            step_q   <= '0;
            k_q      <= '0;
        end else if (start) begin
            hold_cnt <= HOLD_INIT;
            step_cnt <= STEP_INIT;
            step_q   <= step_c;
            k_q      <= k;
        end else if (enable) begin
            if (hold_cnt == HOLD_LAST) begin
                hold_cnt <= '0;
                step_cnt <= step_cnt + STEP_W'(1);
            end else begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end
    end

endmodule

// File: rtl/tx_nco_freq_ctrl.sv
// TX NCO sequencer: clock enable, phase increment, warm-up/settle tracking and cfg handshake.
module tx_nco_freq_ctrl
    import tx_nco_ctrl_pkg::*;
#(
    parameter int unsigned APR       = APR_DEF,
    parameter int unsigned NCO_LAT   = NCO_LAT_DEF,
    parameter int unsigned RAMP_HOLD = RAMP_HOLD_DEF,
    parameter int unsigned KW        = KW_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [APR-1:0] cfg_phi_inc,
    input  logic [KW-1:0]  cfg_ramp_k,
    output logic           nco_clken,
    output logic [APR-1:0] nco_phi_inc,
    input  logic           nco_out_valid,
    output logic           tx_gate,
    output logic           settled,
    output logic           busy
);

    localparam int unsigned CNT_W = $clog2(NCO_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCO_LAT - 1);

    state_e         state;
    state_e         next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic [APR-1:0] target;
    logic [APR-1:0] target_d;
    logic [APR-1:0] phi_d;
    logic [APR-1:0] ramp_phi_c;
    logic           clken_d;
    logic           gate_d;
    logic           settled_d;
    logic           busy_d;
    logic           accept_c;
    logic           cnt_end_c;
    logic           ramp_start_c;
    logic           ramp_en_c;
    logic           ramp_done_c;

    // Handshake and ramp control strobes.
    always_comb begin
        cfg_ready    = (state == OFF) || (state == RUN);
        accept_c     = cfg_valid && cfg_ready;
        cnt_end_c    = (cnt == CNT_LAST);
        ramp_start_c = accept_c && en && (state == RUN) && (cfg_ramp_k != '0);
        ramp_en_c    = en && (state == RAMP);
        target_d     = accept_c ? cfg_phi_inc : target;
    end

    tx_nco_ramp_gen #(
        .APR       (APR),
        .RAMP_HOLD (RAMP_HOLD),
        .KW        (KW)
    ) u_ramp (
        .clk       (clk),
        .reset     (reset),
        .start     (ramp_start_c),
        .k         (cfg_ramp_k),
        .current   (nco_phi_inc),
        .target    (target_d),
        .enable    (ramp_en_c),
        .abort     (~en),
        .phi_out_c (ramp_phi_c),
        .done_c    (ramp_done_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= OFF;
        end else begin
            state <= next_state;
        end
    end

    // Disable from any active state wins over every other transition.
    always_comb begin
        next_state = state;
        if (!en && (state != OFF)) begin
            next_state = OFF;
        end else begin
            case (state)
                OFF:     if (en) next_state = WARMUP;
                WARMUP:  if (cnt_end_c && nco_out_valid) next_state = RUN;
                RUN:     if (accept_c) next_state = (cfg_ramp_k == '0) ? SETTLE : RAMP;
                RAMP:    if (ramp_done_c) next_state = SETTLE;
                SETTLE:  if (cnt_end_c) next_state = RUN;
                default: next_state = OFF;
            endcase
        end
    end

    always_comb begin
        clken_d   = (next_state != OFF);
        gate_d    = (next_state == RUN) || (next_state == RAMP) || (next_state == SETTLE);
        settled_d = (next_state == RUN);
        busy_d    = (next_state == RAMP) || (next_state == SETTLE);
        cnt_d     = '0;
        if ((next_state == state) && ((state == WARMUP) || (state == SETTLE))) begin
            cnt_d = cnt_end_c ? cnt : cnt + CNT_W'(1);
        end
        phi_d = nco_phi_inc;
        if (state == OFF) begin
            if (accept_c) phi_d = cfg_phi_inc;
        end else if (!en) begin
            phi_d = target_d;
        end else if ((state == RUN) && accept_c) begin
            phi_d = (cfg_ramp_k == '0) ? cfg_phi_inc : ramp_phi_c;
        end else if (state == RAMP) begin
            phi_d = ramp_phi_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            target      <= '0;
            nco_phi_inc <= '0;
            nco_clken   <= 1'b0;
            tx_gate     <= 1'b0;
            settled     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            cnt         <= cnt_d;
            target      <= target_d;
            nco_phi_inc <= phi_d;
            nco_clken   <= clken_d;
            tx_gate     <= gate_d;
            settled     <= settled_d;
            busy        <= busy_d;
        end
    end

endmodule
